// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost flags and a
// selectable registered or first-word-fall-through read port.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_BITS     = 3,
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = 6,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_BITS:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned        Depth     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DepthCnt  = (ADDR_BITS + 1)'(Depth);
  localparam logic [ADDR_BITS:0] AfullCnt  = (ADDR_BITS + 1)'(AFULL_THRESH);
  localparam logic [ADDR_BITS:0] AemptyCnt = (ADDR_BITS + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR_BITS:0] One       = (ADDR_BITS + 1)'(1);

  logic [DATA_WIDTH-1:0]  r_mem [Depth];
  logic [ADDR_BITS:0]     r_wptr;
  logic [ADDR_BITS:0]     r_rptr;
  logic [ADDR_BITS:0]     r_count;
  logic                   r_overflow;
  logic                   r_underflow;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_rd_acc;
  logic                   w_wr_acc;
  logic [ADDR_BITS-1:0]   w_waddr;
  logic [ADDR_BITS-1:0]   w_raddr;

  assign w_full   = (r_count == DepthCnt);
  assign w_empty  = (r_count == '0);
  assign w_rd_acc = ren & ~w_empty;
  // A read on the same edge frees a slot, so a full FIFO can still take a write.
  assign w_wr_acc = wen & (~w_full | w_rd_acc);
  assign w_waddr  = r_wptr[ADDR_BITS-1:0];
  assign w_raddr  = r_rptr[ADDR_BITS-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + One;
      if (w_rd_acc) r_rptr <= r_rptr + One;
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + One;
      end else if (w_rd_acc && !w_wr_acc) begin
        r_count <= r_count - One;
      end
      r_overflow  <= wen & ~w_wr_acc;
      r_underflow <= ren & w_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) r_mem[w_waddr] <= wdata;
  end

  if (FWFT != 0) begin : g_fwft
    always_comb begin
      rdata = '0;
      if (!w_empty) rdata = r_mem[w_raddr];
    end
    assign rvalid = ~w_empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rdata  <= '0;
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_rd_acc;
        if (w_rd_acc) r_rdata <= r_mem[w_raddr];
      end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
  end

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AfullCnt);
  assign almost_empty = (r_count <= AemptyCnt);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: three instances (default registered, FWFT, wide with custom
// thresholds) checked against queue-based reference models.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Default instance: depth 8, registered read
  logic       a_wen = 0, a_ren = 0;
  logic [7:0] a_wdata = 0, a_rdata;
  logic       a_rvalid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
  logic [3:0] a_count;

  // FWFT instance: depth 8
  logic       f_wen = 0, f_ren = 0;
  logic [7:0] f_wdata = 0, f_rdata;
  logic       f_rvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [3:0] f_count;

  // Threshold instance: depth 16, 32-bit, afull at 3, aempty at 0
  logic        t_wen = 0, t_ren = 0;
  logic [31:0] t_wdata = 0, t_rdata;
  logic        t_rvalid, t_full, t_empty, t_afull, t_aempty, t_ovf, t_unf;
  logic [4:0]  t_count;

  sync_fifo u_main (
    .clk(clk), .rst(rst), .wen(a_wen), .wdata(a_wdata), .ren(a_ren),
    .rdata(a_rdata), .rvalid(a_rvalid), .full(a_full), .empty(a_empty),
    .almost_full(a_afull), .almost_empty(a_aempty), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf)
  );

  sync_fifo #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wen(f_wen), .wdata(f_wdata), .ren(f_ren),
    .rdata(f_rdata), .rvalid(f_rvalid), .full(f_full), .empty(f_empty),
    .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  sync_fifo #(.DATA_WIDTH(32), .ADDR_BITS(4), .AFULL_THRESH(3), .AEMPTY_THRESH(0)) u_thr (
    .clk(clk), .rst(rst), .wen(t_wen), .wdata(t_wdata), .ren(t_ren),
    .rdata(t_rdata), .rvalid(t_rvalid), .full(t_full), .empty(t_empty),
    .almost_full(t_afull), .almost_empty(t_aempty), .count(t_count),
    .overflow(t_ovf), .underflow(t_unf)
  );

  // Reference models: contents as queues, outputs derived from the acceptance rules.
  logic [7:0]  a_q[$];
  logic [7:0]  a_exp_rdata = 0;
  bit          a_exp_rvalid = 0, a_exp_ovf = 0, a_exp_unf = 0;
  logic [7:0]  f_q[$];
  bit          f_exp_ovf = 0, f_exp_unf = 0;
  logic [31:0] t_q[$];
  logic [31:0] t_exp_rdata = 0;
  bit          t_exp_rvalid = 0, t_exp_ovf = 0, t_exp_unf = 0;

  // Advance one clock edge, then update every model from the inputs held across it.
  task automatic tick();
    bit rd_ok, wr_ok;
    @(posedge clk);
    #1;
    if (rst) begin
      a_q.delete(); f_q.delete(); t_q.delete();
      a_exp_rdata = 0; a_exp_rvalid = 0; a_exp_ovf = 0; a_exp_unf = 0;
      f_exp_ovf = 0; f_exp_unf = 0;
      t_exp_rdata = 0; t_exp_rvalid = 0; t_exp_ovf = 0; t_exp_unf = 0;
    end else begin
      rd_ok = a_ren && a_q.size() > 0;
      wr_ok = a_wen && (a_q.size() < 8 || rd_ok);
      a_exp_ovf = a_wen && !wr_ok;
      a_exp_unf = a_ren && a_q.size() == 0;
      a_exp_rvalid = rd_ok;
      if (rd_ok) a_exp_rdata = a_q.pop_front();
      if (wr_ok) a_q.push_back(a_wdata);

      rd_ok = f_ren && f_q.size() > 0;
      wr_ok = f_wen && (f_q.size() < 8 || rd_ok);
      f_exp_ovf = f_wen && !wr_ok;
      f_exp_unf = f_ren && f_q.size() == 0;
      if (rd_ok) void'(f_q.pop_front());
      if (wr_ok) f_q.push_back(f_wdata);

      rd_ok = t_ren && t_q.size() > 0;
      wr_ok = t_wen && (t_q.size() < 16 || rd_ok);
      t_exp_ovf = t_wen && !wr_ok;
      t_exp_unf = t_ren && t_q.size() == 0;
      t_exp_rvalid = rd_ok;
      if (rd_ok) t_exp_rdata = t_q.pop_front();
      if (wr_ok) t_q.push_back(t_wdata);
    end
  endtask

  // Packed {count, full, empty, afull, aempty, ovf, unf, rvalid, rdata} from each model
  function automatic logic [18:0] a_model();
    int n = a_q.size();
    return {4'(n), n == 8, n == 0, n >= 6, n <= 2, a_exp_ovf, a_exp_unf, a_exp_rvalid, a_exp_rdata};
  endfunction

  function automatic logic [18:0] f_model();
    int n = f_q.size();
    logic [7:0] d = (n > 0) ? f_q[0] : 8'h00;
    return {4'(n), n == 8, n == 0, n >= 6, n <= 2, f_exp_ovf, f_exp_unf, n > 0, d};
  endfunction

  function automatic logic [43:0] t_model();
    int n = t_q.size();
    return {5'(n), n == 16, n == 0, n >= 3, n == 0, t_exp_ovf, t_exp_unf, t_exp_rvalid, t_exp_rdata};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({a_count, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf, a_rvalid, a_rdata}
        !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_main: got cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b rv=%b rd=%h",
               a_count, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf, a_rvalid, a_rdata);
    end
    checks++;
    if ({f_count, f_empty, f_rvalid, f_rdata} !== {4'd0, 1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_fwft: got cnt=%0d e=%b rv=%b rd=%h expected 0 1 0 00",
               f_count, f_empty, f_rvalid, f_rdata);
    end
    checks++;
    if ({t_count, t_empty, t_aempty, t_afull} !== {5'd0, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_thr: got cnt=%0d e=%b ae=%b af=%b expected 0 1 1 0",
               t_count, t_empty, t_aempty, t_afull);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      a_wen = 1; a_wdata = 8'(8'h10 + i);
      tick();
      checks++;
      if ({a_count, a_afull, a_full} !== {4'(i + 1), (i + 1) >= 6, (i + 1) == 8}) begin
        failures++;
        $display("FAIL fill_step%0d: got cnt=%0d af=%b f=%b", i, a_count, a_afull, a_full);
      end
    end
    a_wdata = 8'hEE;
    tick();
    a_wen = 0;
    checks++;
    if (a_ovf !== 1'b1 || a_count !== 4'd8) begin
      failures++;
      $display("FAIL overflow_pulse: got ov=%b cnt=%0d expected 1 8", a_ovf, a_count);
    end
    tick();
    checks++;
    if (a_ovf !== 1'b0) begin
      failures++;
      $display("FAIL overflow_one_cycle: got %b expected 0", a_ovf);
    end
    a_ren = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({a_rvalid, a_rdata, a_count, a_aempty, a_empty}
          !== {1'b1, 8'(8'h10 + i), 4'(7 - i), (7 - i) <= 2, i == 7}) begin
        failures++;
        $display("FAIL drain_step%0d: got rv=%b rd=%h cnt=%0d ae=%b e=%b",
                 i, a_rvalid, a_rdata, a_count, a_aempty, a_empty);
      end
    end
    tick();
    a_ren = 0;
    checks++;
    if (a_unf !== 1'b1 || a_rvalid !== 1'b0 || a_rdata !== 8'h17) begin
      failures++;
      $display("FAIL underflow_pulse: got un=%b rv=%b rd=%h expected 1 0 17",
               a_unf, a_rvalid, a_rdata);
    end
    tick();
    checks++;
    if (a_unf !== 1'b0 || a_rdata !== 8'h17) begin
      failures++;
      $display("FAIL underflow_one_cycle: got un=%b rd=%h expected 0 17", a_unf, a_rdata);
    end
  endtask

  task automatic test_full_simul();
    a_wen = 1;
    for (int i = 0; i < 8; i++) begin
      a_wdata = 8'($urandom);
      tick();
    end
    a_ren = 1;
    for (int i = 0; i < 20; i++) begin
      a_wdata = 8'($urandom);
      tick();
      checks++;
      if ({a_count, a_full, a_ovf, a_rvalid, a_rdata} !== {4'd8, 1'b1, 1'b0, 1'b1, a_exp_rdata}) begin
        failures++;
        $display("FAIL full_simul%0d: got cnt=%0d f=%b ov=%b rv=%b rd=%h expected rd=%h",
                 i, a_count, a_full, a_ovf, a_rvalid, a_rdata, a_exp_rdata);
      end
    end
    a_wen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if ({a_count, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf, a_rvalid, a_rdata}
          !== a_model()) begin
        failures++;
        $display("FAIL full_drain%0d: got %h expected %h",
                 i, {a_count, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf, a_rvalid, a_rdata},
                 a_model());
      end
    end
    a_ren = 0;
  endtask

  task automatic test_empty_simul();
    a_wen = 1; a_ren = 1; a_wdata = 8'h3C;
    tick();
    a_wen = 0;
    checks++;
    if ({a_count, a_unf, a_rvalid} !== {4'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL empty_simul: got cnt=%0d un=%b rv=%b expected 1 1 0", a_count, a_unf, a_rvalid);
    end
    tick();
    a_ren = 0;
    checks++;
    if ({a_count, a_unf, a_rvalid, a_rdata} !== {4'd0, 1'b0, 1'b1, 8'h3C}) begin
      failures++;
      $display("FAIL empty_simul_read: got cnt=%0d un=%b rv=%b rd=%h expected 0 0 1 3c",
               a_count, a_unf, a_rvalid, a_rdata);
    end
  endtask

  task automatic test_fwft();
    f_wen = 1; f_wdata = 8'hA5;
    tick();
    f_wen = 0;
    checks++;
    if (f_rdata !== 8'hA5 || f_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL fwft_fallthrough: got rd=%h rv=%b expected a5 1", f_rdata, f_rvalid);
    end
    tick();
    f_ren = 1;
    checks++;
    if (f_rdata !== 8'hA5 || f_rvalid !== 1'b1 || f_count !== 4'd1) begin
      failures++;
      $display("FAIL fwft_hold: got rd=%h rv=%b cnt=%0d expected a5 1 1", f_rdata, f_rvalid, f_count);
    end
    tick();
    checks++;
    if (f_rdata !== 8'h00 || f_rvalid !== 1'b0 || f_empty !== 1'b1) begin
      failures++;
      $display("FAIL fwft_pop: got rd=%h rv=%b e=%b expected 00 0 1", f_rdata, f_rvalid, f_empty);
    end
    f_wen = 1; f_wdata = 8'h77;
    tick();
    f_wen = 0;
    checks++;
    if ({f_unf, f_count, f_rvalid, f_rdata} !== {1'b1, 4'd1, 1'b1, 8'h77}) begin
      failures++;
      $display("FAIL fwft_empty_simul: got un=%b cnt=%0d rv=%b rd=%h expected 1 1 1 77",
               f_unf, f_count, f_rvalid, f_rdata);
    end
    tick();
    f_ren = 0;
    checks++;
    if ({f_unf, f_empty, f_rvalid} !== {1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL fwft_drain: got un=%b e=%b rv=%b expected 0 1 0", f_unf, f_empty, f_rvalid);
    end
  endtask

  task automatic test_thresholds();
    t_wen = 1;
    for (int i = 0; i < 17; i++) begin
      t_wdata = $urandom;
      tick();
      checks++;
      if ({t_count, t_afull, t_aempty, t_full, t_ovf}
          !== {5'(i < 16 ? i + 1 : 16), i >= 2, 1'b0, i >= 15, i == 16}) begin
        failures++;
        $display("FAIL thr_fill%0d: got cnt=%0d af=%b ae=%b f=%b ov=%b",
                 i, t_count, t_afull, t_aempty, t_full, t_ovf);
      end
    end
    t_wen = 0; t_ren = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if ({t_count, t_full, t_empty, t_afull, t_aempty, t_ovf, t_unf, t_rvalid, t_rdata}
          !== t_model()) begin
        failures++;
        $display("FAIL thr_drain%0d: got %h expected %h", i,
                 {t_count, t_full, t_empty, t_afull, t_aempty, t_ovf, t_unf, t_rvalid, t_rdata},
                 t_model());
      end
    end
    t_ren = 0;
    tick();
  endtask

  task automatic test_random();
    int p;
    for (int c = 0; c < 600; c++) begin
      p = ((c / 100) % 2 == 0) ? 70 : 30;
      a_wen = $urandom_range(99) < p;  a_ren = $urandom_range(99) < 50;  a_wdata = 8'($urandom);
      f_wen = $urandom_range(99) < p;  f_ren = $urandom_range(99) < 50;  f_wdata = 8'($urandom);
      t_wen = $urandom_range(99) < p;  t_ren = $urandom_range(99) < 50;  t_wdata = $urandom;
      tick();
      checks++;
      if ({a_count, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf, a_rvalid, a_rdata}
          !== a_model()) begin
        failures++;
        $display("FAIL rand_main%0d: got %h expected %h", c,
                 {a_count, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf, a_rvalid, a_rdata},
                 a_model());
      end
      checks++;
      if ({f_count, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf, f_rvalid, f_rdata}
          !== f_model()) begin
        failures++;
        $display("FAIL rand_fwft%0d: got %h expected %h", c,
                 {f_count, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf, f_rvalid, f_rdata},
                 f_model());
      end
      checks++;
      if ({t_count, t_full, t_empty, t_afull, t_aempty, t_ovf, t_unf, t_rvalid, t_rdata}
          !== t_model()) begin
        failures++;
        $display("FAIL rand_thr%0d: got %h expected %h", c,
                 {t_count, t_full, t_empty, t_afull, t_aempty, t_ovf, t_unf, t_rvalid, t_rdata},
                 t_model());
      end
    end
    a_wen = 0; a_ren = 0; f_wen = 0; f_ren = 0; t_wen = 0; t_ren = 0;
  endtask

  task automatic test_reset_mid();
    a_ren = 1;
    for (int i = 0; i < 10 && a_q.size() > 0; i++) tick();
    a_ren = 0;
    a_wen = 1;
    for (int i = 0; i < 5; i++) begin
      a_wdata = 8'(8'h60 + i);
      tick();
    end
    checks++;
    if (a_count !== 4'd5) begin
      failures++;
      $display("FAIL reset_mid_setup: got cnt=%0d expected 5", a_count);
    end
    a_ren = 1; a_wdata = 8'hFF; rst = 1;
    tick();
    rst = 0; a_wen = 0; a_ren = 0;
    checks++;
    if ({a_count, a_empty, a_rvalid, a_ovf, a_unf} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid: got cnt=%0d e=%b rv=%b ov=%b un=%b expected 0 1 0 0 0",
               a_count, a_empty, a_rvalid, a_ovf, a_unf);
    end
    a_wen = 1; a_wdata = 8'h5A;
    tick();
    a_wen = 0; a_ren = 1;
    tick();
    a_ren = 0;
    checks++;
    if ({a_rvalid, a_rdata, a_empty, a_unf} !== {1'b1, 8'h5A, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_newdata: got rv=%b rd=%h e=%b un=%b expected 1 5a 1 0",
               a_rvalid, a_rdata, a_empty, a_unf);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_empty_simul();
    test_fwft();
    test_thresholds();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO that generalises the team's dual-clock FIFO for same-domain buffering. Depth and width are set by parameters. A mode parameter selects a registered-read or first-word-fall-through read port. The block adds an occupancy count, programmable almost-full/almost-empty thresholds, and simultaneous read/write when full. Typical use is between pipeline stages in one clock domain, where a gray-code crossing would only add latency.

## Interface
- DATA_WIDTH, 8: word width in bits.
- ADDR_BITS, 3: depth = 2^ADDR_BITS; legal range 1..12.
- FWFT, 0: read mode. 0 = registered read, 1 = first-word-fall-through.
- AFULL_THRESH, 6: almost_full asserts at count >= value; legal range 1..DEPTH.
- AEMPTY_THRESH, 2: almost_empty asserts at count <= value; legal range 0..DEPTH-1.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- wen  in  1  write request.
- wdata  in  DATA_WIDTH  write data.
- ren  in  1  read request.
- rdata  out  DATA_WIDTH  read data.
- rvalid  out  1  rdata is valid.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_BITS+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected on the previous edge.
- underflow  out  1  one-cycle pulse: a read was rejected on the previous edge.

## Operation
**Storage and pointers**
- Storage is a DEPTH x DATA_WIDTH array.
- wptr and rptr are ADDR_BITS+1-bit binary counters. The array is addressed with the low ADDR_BITS bits; the counters wrap modulo 2·DEPTH.
- count is a registered counter: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither are accepted.
- The flags (full, empty, almost_full, almost_empty) are combinational decodes of the registered count.

**Acceptance rules**, evaluated against the pre-edge state:
- Read accepted when ren & ~empty.
- Write accepted when wen & (~full | (ren & ~empty)). When full, a simultaneous read frees a slot, so both operations complete and count stays at DEPTH.
- When empty with wen & ren: the write is accepted, the read is rejected, and underflow pulses. This holds in both modes.
- Rejected operations change no state other than the error pulses.

**Error pulses**
- overflow <= wen & ~(write accepted).
- underflow <= ren & empty.
- Both are registered and high for exactly one cycle per rejected request.

**Read port, FWFT=0**
- On an accepted read, rdata <= mem[rptr] and rvalid <= 1.
- Otherwise rvalid <= 0 and rdata holds its last value.

**Read port, FWFT=1**
- rdata = mem[rptr] combinationally, forced to 0 when empty.
- rvalid = ~empty.
- ren acknowledges the current word; the next word appears after the edge.

**Reset** (rst high at a clock edge)
- Pointers and count go to 0. Array contents are not cleared, but become unreachable.
- wen and ren on that edge are ignored. Reset mid-operation discards all buffered data.

**Reset values**
- count 0, empty 1, almost_empty 1, full 0, almost_full 0.
- rdata 0, rvalid 0, overflow 0, underflow 0.

## Timing
- Write to flags: an accepted write at edge N is reflected in count and all flags after edge N.
- Write to readable:
  - FWFT=1: a word written into an empty FIFO at edge N is on rdata with rvalid=1 after edge N.
  - FWFT=0: that word can be requested by ren in the cycle after edge N, and appears on rdata after the following edge.
- Read latency: FWFT=0 is 1 cycle from the ren-accepting edge; FWFT=1 is 0 cycles, since data is present before ren.
- Throughput: one write and one read per cycle, sustained, at any occupancy from 1 to DEPTH.
- Pointer wrap: no bubble and no flag glitch when crossing DEPTH-1 -> 0 or 2·DEPTH-1 -> 0.
- Error pulses: overflow and underflow are high for the cycle after the offending edge.

## Test plan
- **Fill/drain, defaults, FWFT=0:** write 8 words 0x10..0x17, then read 8.
  - Response: count steps 1..8; almost_full at count 6; full at 8.
  - rdata = 0x10..0x17, each one cycle after its ren edge; empty after the 8th read; almost_empty while count <= 2.
- **Overflow/underflow:** a 9th write while full -> overflow high for one cycle, count stays 8, the 0x17 entry is unchanged. ren while empty -> underflow for one cycle, rdata holds.
- **Simultaneous at boundaries:**
  - Full plus wen & ren for 20 cycles -> count stays 8, no overflow, data order preserved across pointer wrap.
  - Empty plus wen & ren -> count 1, underflow pulse, the written word is retained.
- **FWFT=1:** write 0xA5 into an empty FIFO -> rdata = 0xA5, rvalid = 1 on the next cycle with no ren; ren pops it -> rvalid 0, rdata 0.
- **Thresholds:** AFULL_THRESH=3, AEMPTY_THRESH=0, ADDR_BITS=4, DATA_WIDTH=32.
  - almost_full rises exactly at count 3.
  - almost_empty is high only at count 0.
  - count reaches 16 with full.
- **Reset mid-operation:** assert rst at count 5 with wen & ren high -> next cycle count 0, empty 1, rvalid 0, no error pulses; a subsequent write/read returns the new data only.
